// File: rtl/vga_scan_timing_if.sv
// vga_scan_timing_if
//  Bundles the pixel-side signals of the VGA timing block.
//  master : sprite/colour source + pix_en driver (consumes counters, sync, DAC outputs)
//  slave  : vga_scan_timing itself
//  Signals:
//    pix_en                     pixel-clock enable
//    x_cnt, y_cnt [9:0]         registered raster position
//    active                     current (x,y) lies in the visible area
//    frame_start                one-clk pulse at (0,0) on a pix_en cycle
//    r_in, g_in, b_in [7:0]     sprite colour for the current position
//    vga_r, vga_g, vga_b [7:0]  registered colour to the DAC
//    vga_hs, vga_vs             active-low syncs, registered
//    vga_blank_n, vga_sync_n    DAC blank (registered active) / sync-on-green (tied 0)
interface vga_scan_timing_if;
  logic       pix_en;
  logic [9:0] x_cnt;
  logic [9:0] y_cnt;
  logic       active;
  logic       frame_start;
  logic [7:0] r_in, g_in, b_in;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs;
  logic       vga_blank_n, vga_sync_n;

  modport master (
    output pix_en, r_in, g_in, b_in,
    input  x_cnt, y_cnt, active, frame_start,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n
  );

  modport slave (
    input  pix_en, r_in, g_in, b_in,
    output x_cnt, y_cnt, active, frame_start,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n
  );
endinterface

// File: rtl/vga_scan_timing.sv
// vga_scan_timing
//  640x480@60 raster generator. Exposes x/y counters to the sprite layers and
//  registers their merged colour together with sync/blank so that everything
//  reaches the DAC aligned, one pix_en step behind the counters.
//  Ports:
//    clk   system clock (pix_en qualifies pixel steps)
//    rst   asynchronous active-high reset
//    bus   vga_scan_timing_if.slave (see interface header for signal list)
module vga_scan_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic              clk,
  input  logic              rst,
  vga_scan_timing_if.slave  bus
);
  // Totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_x, r_y;
  logic       r_hs, r_vs, r_blank_n;
  logic [7:0] r_r, r_g, r_b;
  logic       w_active, w_hs_win, w_vs_win;

  assign w_active = (r_x < H_ACT) && (r_y < V_ACT);
  assign w_hs_win = (r_x >= HS_BEG) && (r_x < HS_END);
  assign w_vs_win = (r_y >= VS_BEG) && (r_y < VS_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
    end else if (bus.pix_en) begin
      if (r_x == H_MAX) begin
        r_x <= '0;
        r_y <= (r_y == V_MAX) ? 10'd0 : r_y + 10'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
      // Output stage reflects the pre-edge position, so colour from the
      // combinational sprite decode lines up with its sync/blank.
      r_hs      <= ~w_hs_win;
      r_vs      <= ~w_vs_win;
      r_blank_n <= w_active;
      r_r       <= w_active ? bus.r_in : 8'd0;
      r_g       <= w_active ? bus.g_in : 8'd0;
      r_b       <= w_active ? bus.b_in : 8'd0;
    end
  end

  assign bus.x_cnt       = r_x;
  assign bus.y_cnt       = r_y;
  assign bus.active      = w_active;
  // Masked by rst so the pulse cannot appear while the block is held in reset.
  assign bus.frame_start = bus.pix_en && !rst && (r_x == 10'd0) && (r_y == 10'd0);
  assign bus.vga_r       = r_r;
  assign bus.vga_g       = r_g;
  assign bus.vga_b       = r_b;
  assign bus.vga_hs      = r_hs;
  assign bus.vga_vs      = r_vs;
  assign bus.vga_blank_n = r_blank_n;
  assign bus.vga_sync_n  = 1'b0;
endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing
//  Directed bench: full-size instance for line-level timing, pix_en gating and
//  mid-line reset; a shrunken instance (15x8 raster) for frame/vsync/wrap behaviour.
module tb_vga_scan_timing;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  vga_scan_timing_if ifa();
  vga_scan_timing_if ifb();

  vga_scan_timing u_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));

  vga_scan_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  int n_cmp = 0;
  int n_bad = 0;
  string       sb_tag[$];
  logic [31:0] sb_exp[$];

  task automatic push(input string t, input logic [31:0] e);
    sb_tag.push_back(t);
    sb_exp.push_back(e);
  endtask

  task automatic chk(input logic [31:0] o);
    string t;
    logic [31:0] e;
    n_cmp++;
    if (sb_exp.size() == 0) begin
      n_bad++;
      $error("FAIL sb_underflow: got %0h with no expectation queued", o);
      return;
    end
    t = sb_tag.pop_front();
    e = sb_exp.pop_front();
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", t, o, e);
    end
  endtask

  function automatic logic [23:0] rgb_a();
    return {ifa.vga_r, ifa.vga_g, ifa.vga_b};
  endfunction

  function automatic logic [46:0] snap_a();
    return {ifa.x_cnt, ifa.y_cnt, ifa.vga_hs, ifa.vga_vs, ifa.vga_blank_n, rgb_a()};
  endfunction

  initial begin
    int ff, hs0, vs0, first_hs, hold_bad, fs_cnt, fs_first, fs_second;
    logic [23:0] rgb640, rgb641;
    logic act639, act640;
    logic [46:0] snap;

    rst_a = 1'b1; rst_b = 1'b1;
    ifa.pix_en = 1'b0; ifb.pix_en = 1'b0;
    ifa.r_in = 8'hFF; ifa.g_in = 8'hFF; ifa.b_in = 8'hFF;
    ifb.r_in = 8'hFF; ifb.g_in = 8'hFF; ifb.b_in = 8'hFF;
    repeat (3) @(negedge clk);

    // Reset state, with pix_en already high (edges pass while held)
    ifa.pix_en = 1'b1;
    @(negedge clk);
    push("rst_x", 0);        chk(ifa.x_cnt);
    push("rst_y", 0);        chk(ifa.y_cnt);
    push("rst_hs", 1);       chk(ifa.vga_hs);
    push("rst_vs", 1);       chk(ifa.vga_vs);
    push("rst_blank_n", 0);  chk(ifa.vga_blank_n);
    push("rst_rgb", 0);      chk(rgb_a());
    push("sync_n", 0);       chk(ifa.vga_sync_n);
    push("rst_fs", 0);       chk(ifa.frame_start);

    // First line with pix_en held high
    rst_a = 1'b0;
    #1;
    push("fs_at_origin", 1); chk(ifa.frame_start);
    ff = 0; hs0 = 0; vs0 = 0; first_hs = -1;
    rgb640 = 'x; rgb641 = 'x; act639 = 1'bx; act640 = 1'bx;
    push("x_after_799", 799);
    push("y_after_799", 0);
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (rgb_a() == 24'hFFFFFF) ff++;
      if (ifa.vga_hs == 1'b0) begin
        hs0++;
        if (first_hs < 0) first_hs = int'(ifa.x_cnt);
      end
      if (ifa.vga_vs == 1'b0) vs0++;
      if (ifa.x_cnt == 10'd639) act639 = ifa.active;
      if (ifa.x_cnt == 10'd640) begin act640 = ifa.active; rgb640 = rgb_a(); end
      if (ifa.x_cnt == 10'd641) rgb641 = rgb_a();
      if (i == 799) begin chk(ifa.x_cnt); chk(ifa.y_cnt); end
    end
    push("x_wrap", 0);          chk(ifa.x_cnt);
    push("y_inc", 1);           chk(ifa.y_cnt);
    push("rgb_after_799", 0);   chk(rgb_a());
    push("blank_after_799", 0); chk(ifa.vga_blank_n);
    push("rgb_ff_count", 640);  chk(ff);
    push("hs_low_count", 96);   chk(hs0);
    push("hs_first_x", 657);    chk(first_hs);
    push("vs_low_line0", 0);    chk(vs0);
    push("active_639", 1);      chk(act639);
    push("active_640", 0);      chk(act640);
    push("rgb_pre639", 24'hFFFFFF); chk(rgb640);
    push("rgb_pre640", 0);      chk(rgb641);

    // pix_en toggling: line takes 1600 clks, registers hold on disabled edges
    hold_bad = 0; hs0 = 0;
    push("tog_x", 0);
    push("tog_y", 2);
    push("tog_hold_viol", 0);
    push("tog_hs_low_clks", 192);
    for (int i = 0; i < 1600; i++) begin
      ifa.pix_en = (i % 2 == 0);
      snap = snap_a();
      @(negedge clk);
      if (!ifa.pix_en && snap_a() != snap) hold_bad++;
      if (ifa.vga_hs == 1'b0) hs0++;
    end
    chk(ifa.x_cnt);
    chk(ifa.y_cnt);
    chk(hold_bad);
    chk(hs0);

    // Mid-line asynchronous reset
    ifa.pix_en = 1'b1;
    repeat (300) @(negedge clk);
    push("mid_x", 300);          chk(ifa.x_cnt);
    push("mid_blank", 1);        chk(ifa.vga_blank_n);
    push("mid_rgb", 24'hFFFFFF); chk(rgb_a());
    #2 rst_a = 1'b1;
    #1;
    push("arst_x", 0);       chk(ifa.x_cnt);
    push("arst_y", 0);       chk(ifa.y_cnt);
    push("arst_blank", 0);   chk(ifa.vga_blank_n);
    push("arst_rgb", 0);     chk(rgb_a());
    push("arst_hs", 1);      chk(ifa.vga_hs);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    push("post_rst_x", 1);   chk(ifa.x_cnt);
    push("post_rst_y", 0);   chk(ifa.y_cnt);

    // Small raster (15 x 8): two full frames
    rst_b = 1'b0;
    ifb.pix_en = 1'b1;
    #1;
    push("b_fs_origin", 1);  chk(ifb.frame_start);
    fs_cnt = 0; fs_first = -1; fs_second = -1; vs0 = 0; hs0 = 0; ff = 0;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      if (ifb.frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (ifb.vga_vs == 1'b0) vs0++;
      if (ifb.vga_hs == 1'b0) hs0++;
      if ({ifb.vga_r, ifb.vga_g, ifb.vga_b} == 24'hFFFFFF) ff++;
    end
    push("b_fs_count", 2);     chk(fs_cnt);
    push("b_fs_first", 120);   chk(fs_first);
    push("b_fs_second", 240);  chk(fs_second);
    push("b_vs_low", 60);      chk(vs0);
    push("b_hs_low", 48);      chk(hs0);
    push("b_rgb_ff", 64);      chk(ff);

    // Wrap corner (14,7) -> (0,0)
    repeat (119) @(negedge clk);
    push("b_corner_x", 14);  chk(ifb.x_cnt);
    push("b_corner_y", 7);   chk(ifb.y_cnt);
    push("b_corner_fs", 0);  chk(ifb.frame_start);
    @(negedge clk);
    push("b_wrap_x", 0);     chk(ifb.x_cnt);
    push("b_wrap_y", 0);     chk(ifb.y_cnt);
    push("b_wrap_fs", 1);    chk(ifb.frame_start);
    ifb.pix_en = 1'b0;
    #1;
    push("b_fs_gated", 0);   chk(ifb.frame_start);
    @(negedge clk);
    push("b_hold_x", 0);     chk(ifb.x_cnt);

    if (sb_exp.size() != 0) begin
      n_cmp++; n_bad++;
      $error("FAIL sb_leftover: got %0d entries expected 0", sb_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
